// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory boot
//            loader: FSM state encoding, frame sync byte, length-field width
//            and bytes per instruction word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader FSM states. CHECK is only reachable when the checksum build
    // option is enabled.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         LEN_W          = 16;
    localparam int         BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader_if
// Purpose  : Bundles the loader's byte-stream input, instruction-memory write
//            port and status outputs.
// Ports    : master - loader side (consumes rx bytes, drives imem/status)
//            slave  - environment side (byte source, imem, core control)
//            Signals: rx_valid, rx_data[7:0], rx_ready, imem_we,
//            imem_waddr[ADDR_W-1:0], imem_wdata[31:0], core_reset,
//            load_done, load_error.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_error;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_waddr, imem_wdata,
               core_reset, load_done, load_error
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_waddr, imem_wdata,
               core_reset, load_done, load_error
    );
endinterface : imem_boot_loader_if
`default_nettype wire

// File: rtl/imem_boot_loader_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_packer
// Purpose  : Packs accepted bytes into 32-bit little-endian words. The first
//            byte of a word lands in bits 7:0. word_valid/word are presented
//            combinationally in the cycle the fourth byte is offered so the
//            parent can register the memory write on the same edge.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            clear           - discard any partly assembled word
//            byte_valid      - byte_data is being accepted this cycle
//            byte_data[7:0]  - incoming byte
//            word_valid      - this byte completes a word
//            word[31:0]      - completed word (valid with word_valid)
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] r_shift;
    logic [1:0]  r_byte_cnt;

    // Older bytes sit in the low positions, so the newest byte tops the word.
    assign word_valid = byte_valid && !clear && (r_byte_cnt == c_LAST_BYTE);
    assign word       = {byte_data, r_shift};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (byte_valid) begin
            r_shift    <= {byte_data, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

endmodule : byte_word_packer
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Receives a framed byte stream (A5, LEN_LO, LEN_HI, 4*N payload
//            bytes [, CSUM]), writes the payload as 32-bit words into the
//            instruction memory and holds the core in reset until a complete
//            image is loaded.
// Build    : IMEM_LOADER_CHECKSUM_EN - when defined, the frame carries a
//            trailing XOR checksum byte that is verified in the CHECK state.
//            When undefined, the load completes after the last word write.
// Ports    : clk        - system clock
//            reset      - synchronous, active-high reset
//            bus        - imem_boot_loader_if.master (rx stream, imem write
//                         port, core_reset, load_done, load_error)
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.master  bus
);

    // Word index is one bit wider than the address so a full-memory image
    // counts up to 2**ADDR_W without wrapping.
    localparam int               c_IDX_W     = ADDR_W + 1;
    localparam int               c_TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W:0]   c_MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

    state_t               r_state;
    logic [7:0]           r_len_lo;
    logic [LEN_W-1:0]     r_len;
    logic [c_IDX_W-1:0]   r_word_idx;
    logic [c_TO_W-1:0]    r_idle;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           r_csum;
`endif

    logic                 r_rx_ready;
    logic                 r_imem_we;
    logic [ADDR_W-1:0]    r_imem_waddr;
    logic [31:0]          r_imem_wdata;
    logic                 r_core_reset;
    logic                 r_load_done;
    logic                 r_load_error;

    logic                 w_take;
    logic                 w_counting;
    logic                 w_timeout;
    logic                 w_is_sync;
    logic [LEN_W:0]       w_len_ext;
    logic                 w_is_last;
    logic                 w_word_valid;
    logic [31:0]          w_word;

    assign w_take     = bus.rx_valid && r_rx_ready;
    assign w_is_sync  = (bus.rx_data == SYNC_BYTE);
    assign w_counting = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                        (r_state == ST_DATA)   || (r_state == ST_CHECK);
    assign w_timeout  = (r_idle == c_TO_LAST);
    assign w_len_ext  = {1'b0, bus.rx_data, r_len_lo};
    assign w_is_last  = ((LEN_W + 1)'(r_word_idx) + 1'b1) == (LEN_W + 1)'(r_len);

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (r_state != ST_DATA),
        .byte_valid (w_take && (r_state == ST_DATA)),
        .byte_data  (bus.rx_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len_lo     <= '0;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_idle       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
            r_rx_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;

            // Inter-byte idle counter; only meaningful inside a frame.
            if (w_take || !w_counting) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (w_take && w_is_sync) begin
                        r_state      <= ST_LEN_LO;
                        r_word_idx   <= '0;
                        r_load_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum       <= '0;
`endif
                    end
                end

                ST_LEN_LO: begin
                    if (w_take) begin
                        r_len_lo <= bus.rx_data;
                        r_state  <= ST_LEN_HI;
                    end else if (w_timeout) begin
                        r_state      <= ST_ERROR;
                        r_load_error <= 1'b1;
                    end
                end

                ST_LEN_HI: begin
                    if (w_take) begin
                        r_len <= w_len_ext[LEN_W-1:0];
                        if (w_len_ext > c_MAX_WORDS) begin
                            r_state      <= ST_ERROR;
                            r_load_error <= 1'b1;
                        end else if (w_len_ext == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state      <= ST_CHECK;
`else
                            r_state      <= ST_DONE;
                            r_rx_ready   <= 1'b0;
                            r_core_reset <= 1'b0;
                            r_load_done  <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else if (w_timeout) begin
                        r_state      <= ST_ERROR;
                        r_load_error <= 1'b1;
                    end
                end

                ST_DATA: begin
`ifndef IMEM_LOADER_CHECKSUM_EN
                    // rx_ready is only low here during the one cycle after the
                    // final write; completing now puts load_done a cycle
                    // behind the last imem_we.
                    if (!r_rx_ready) begin
                        r_state      <= ST_DONE;
                        r_core_reset <= 1'b0;
                        r_load_done  <= 1'b1;
                    end else
`endif
                    if (w_take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.rx_data;
`endif
                        if (w_word_valid) begin
                            r_imem_we    <= 1'b1;
                            r_imem_waddr <= r_word_idx[ADDR_W-1:0];
                            r_imem_wdata <= w_word;
                            r_word_idx   <= r_word_idx + 1'b1;
                            if (w_is_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state    <= ST_CHECK;
`else
                                r_rx_ready <= 1'b0;
`endif
                            end
                        end
                    end else if (w_timeout) begin
                        r_state      <= ST_ERROR;
                        r_load_error <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_take) begin
                        if (bus.rx_data == r_csum) begin
                            r_state      <= ST_DONE;
                            r_rx_ready   <= 1'b0;
                            r_core_reset <= 1'b0;
                            r_load_done  <= 1'b1;
                        end else begin
                            r_state      <= ST_ERROR;
                            r_load_error <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state      <= ST_ERROR;
                        r_load_error <= 1'b1;
                    end
                end
`endif

                ST_DONE: begin
                    // Terminal until reset; input is ignored (rx_ready is low).
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_waddr = r_imem_waddr;
    assign bus.imem_wdata = r_imem_wdata;
    // Core stays in reset while the system reset is asserted, without waiting
    // for the registered value to settle.
    assign bus.core_reset = r_core_reset | reset;
    assign bus.load_done  = r_load_done;
    assign bus.load_error = r_load_error;

endmodule : imem_boot_loader
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench for imem_boot_loader. Frames are built from
//            word lists; expected memory writes, final status and completion
//            timing are derived from the frame format rules.
// Build    : IMEM_LOADER_CHECKSUM_EN selects whether frames carry a CSUM byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int ADDR_W         = 8;
    localparam int TIMEOUT_CYCLES = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_acc;
    int          done_cyc;
    int          err_cyc;
    logic [7:0]  tx_q[$];
    logic [31:0] words[$];
    logic [39:0] exp_wr[$];
    logic [39:0] obs_wr[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/status monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) obs_wr.push_back({bus.imem_waddr, bus.imem_wdata});
        if (bus.load_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (bus.load_error === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        settle(2);
        check("reset_core_reset_held", 64'(bus.core_reset), 64'd1);
        reset = 1'b0;
        obs_wr.delete();
        exp_wr.delete();
        tx_q.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},   64'(bus.rx_ready),   64'd1);
        check({tag, "_imem_we"},    64'(bus.imem_we),    64'd0);
        check({tag, "_imem_waddr"}, 64'(bus.imem_waddr), 64'd0);
        check({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
        check({tag, "_core_reset"}, 64'(bus.core_reset), 64'd1);
        check({tag, "_load_done"},  64'(bus.load_done),  64'd0);
        check({tag, "_load_error"}, 64'(bus.load_error), 64'd0);
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard        = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.rx_ready !== 1'b1) check("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
        last_acc = cyc + 1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        settle(gap);
    endtask

    task automatic send_frame(input int max_gap);
        foreach (tx_q[i]) send_byte(tx_q[i], int'($urandom_range(0, max_gap)));
        tx_q.delete();
    endtask

    task automatic rand_words(input int n, input bit a5_rich);
        logic [31:0] w;
        int          k;
        words.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (a5_rich && $urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, 3));
                w[8*k +: 8] = 8'hA5;
            end
            words.push_back(w);
        end
    endtask

    // Frame: A5, N little-endian, payload little-endian per word, [XOR csum].
    task automatic build_frame(input bit bad_csum);
        logic [7:0]  x;
        logic [7:0]  v;
        logic [15:0] n;
        x = 8'h00;
        n = 16'(words.size());
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) begin
                v = 8'(words[i] >> (8 * b));
                tx_q.push_back(v);
                x = x ^ v;
            end
            exp_wr.push_back({8'(i), words[i]});
        end
        if (CS_EN) tx_q.push_back(x ^ {7'd0, bad_csum});
    endtask

    function automatic int exp_cyc(input bit is_err, input int n);
        return is_err ? last_acc : last_acc + ((!CS_EN && n > 0) ? 1 : 0);
    endfunction

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(obs_wr[i]), 64'(exp_wr[i]));
    endtask

    task automatic check_outcome(input string tag, input bit is_err, input int want_cyc);
        check({tag, "_load_done"},  64'(bus.load_done),  64'(!is_err));
        check({tag, "_load_error"}, 64'(bus.load_error), 64'(is_err));
        check({tag, "_core_reset"}, 64'(bus.core_reset), 64'(is_err));
        check({tag, "_rx_ready"},   64'(bus.rx_ready),   64'(is_err));
        check({tag, "_cycle"}, 64'(is_err ? err_cyc : done_cyc), 64'(want_cyc));
        check_writes(tag);
    endtask

    initial begin
        int  n;
        bit  bad;
        int  want;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        done_cyc     = -1;
        err_cyc      = -1;

        // Reset values and nominal two-word load.
        do_reset();
        check_reset_values("init");
        words = '{32'h0000_0013, 32'h0010_0093};
        build_frame(1'b0);
        send_frame(2);
        want = exp_cyc(1'b0, 2);
        settle(4);
        check_outcome("nominal", 1'b0, want);
        check("nominal_waddr", 64'(bus.imem_waddr), 64'd1);

        // DONE ignores a held rx_valid.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        settle(6);
        bus.rx_valid = 1'b0;
        check("done_ignore_wr_count", 64'(obs_wr.size()), 64'd2);
        check("done_ignore_load_done", 64'(bus.load_done), 64'd1);

        // Error frame (bad csum, or over-length without checksum), then resend.
        do_reset();
        if (CS_EN) begin
            words = '{32'h0000_0013, 32'h0010_0093};
            build_frame(1'b1);
        end else begin
            tx_q = '{8'hA5, 8'h01, 8'h01};
        end
        send_frame(2);
        want = exp_cyc(1'b1, 2);
        settle(4);
        check_outcome("err_frame", 1'b1, want);
        words = '{32'h0000_0013, 32'h0010_0093};
        build_frame(1'b0);
        send_frame(2);
        want = exp_cyc(1'b0, 2);
        settle(4);
        check_outcome("resend", 1'b0, want);

        // Over-length N=257, garbage in ERROR, then a one-word frame.
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h01};
        send_frame(1);
        want = exp_cyc(1'b1, 257);
        settle(3);
        check_outcome("overlen", 1'b1, want);
        tx_q = '{8'h00, 8'hFF, 8'h12};
        send_frame(1);
        check("overlen_garbage_err", 64'(bus.load_error), 64'd1);
        rand_words(1, 1'b1);
        build_frame(1'b0);
        send_frame(1);
        want = exp_cyc(1'b0, 1);
        settle(4);
        check_outcome("after_overlen", 1'b0, want);

        // Garbage in IDLE before sync.
        do_reset();
        tx_q = '{8'h00, 8'hFF};
        rand_words(1, 1'b0);
        build_frame(1'b0);
        send_frame(2);
        want = exp_cyc(1'b0, 1);
        settle(4);
        check_outcome("garbage_sync", 1'b0, want);

        // Full memory N = 2**ADDR_W.
        do_reset();
        rand_words(2 ** ADDR_W, 1'b1);
        build_frame(1'b0);
        send_frame(1);
        want = exp_cyc(1'b0, 2 ** ADDR_W);
        settle(4);
        check_outcome("full_mem", 1'b0, want);

        // Empty image N = 0.
        do_reset();
        words.delete();
        build_frame(1'b0);
        send_frame(1);
        want = exp_cyc(1'b0, 0);
        settle(4);
        check_outcome("empty", 1'b0, want);

        // Stall after two payload bytes.
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_frame(0);
        while (err_cyc < 0 && cyc < last_acc + 40) @(negedge clk);
        check("stall_err_cycle", 64'(err_cyc), 64'(last_acc + TIMEOUT_CYCLES));
        check("stall_load_error", 64'(bus.load_error), 64'd1);
        check("stall_core_reset", 64'(bus.core_reset), 64'd1);
        check("stall_wr_count", 64'(obs_wr.size()), 64'd0);

        // Reset in the middle of a word.
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h33, 8'h44, 8'h55};
        send_frame(1);
        settle(2);
        check("midword_wr_before", 64'(obs_wr.size()), 64'd0);
        do_reset();
        check_reset_values("midword");
        settle(3);
        check("midword_wr_after", 64'(obs_wr.size()), 64'd0);
        rand_words(3, 1'b1);
        build_frame(1'b0);
        send_frame(3);
        want = exp_cyc(1'b0, 3);
        settle(4);
        check_outcome("midword_reload", 1'b0, want);

        // Randomized frames, sync bytes mixed into payload.
        for (int k = 0; k < 6; k++) begin
            do_reset();
            n   = int'($urandom_range(1, 6));
            bad = CS_EN && ($urandom_range(0, 1) == 1);
            rand_words(n, 1'b1);
            build_frame(bad);
            send_frame(3);
            want = exp_cyc(bad, n);
            settle(4);
            check_outcome($sformatf("rand%0d", k), bad, want);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_imem_boot_loader
`default_nettype wire
